// File: rtl/blockmem_2p_arbiter.sv
// Two-requester front end for a simple dual-port block memory: independent round-robin
// arbitration of the write port (A) and the read port (B), with the read data routed to its issuer.
module blockmem_2p_arbiter #(
  parameter int G_DATAWIDTH       = 32,
  parameter int G_MEMDEPTH        = 1024,
  parameter int G_ADDRWIDTH       = $clog2(G_MEMDEPTH),
  parameter int G_WEWIDTH         = ((G_DATAWIDTH-1)/8)+1,
  parameter int G_RD_LATENCY      = 1,
  parameter int G_COLLISION_STALL = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  // requester 0
  input  logic                   m0_wr_valid,
  output logic                   m0_wr_ready,
  input  logic [G_ADDRWIDTH-1:0] m0_waddr,
  input  logic [G_DATAWIDTH-1:0] m0_wdata,
  input  logic [G_WEWIDTH-1:0]   m0_wstrb,
  input  logic                   m0_rd_valid,
  output logic                   m0_rd_ready,
  input  logic [G_ADDRWIDTH-1:0] m0_raddr,
  output logic [G_DATAWIDTH-1:0] m0_rdata,
  output logic                   m0_rvalid,
  // requester 1
  input  logic                   m1_wr_valid,
  output logic                   m1_wr_ready,
  input  logic [G_ADDRWIDTH-1:0] m1_waddr,
  input  logic [G_DATAWIDTH-1:0] m1_wdata,
  input  logic [G_WEWIDTH-1:0]   m1_wstrb,
  input  logic                   m1_rd_valid,
  output logic                   m1_rd_ready,
  input  logic [G_ADDRWIDTH-1:0] m1_raddr,
  output logic [G_DATAWIDTH-1:0] m1_rdata,
  output logic                   m1_rvalid,
  // memory side
  output logic                   ena,
  output logic [G_WEWIDTH-1:0]   wea,
  output logic [G_ADDRWIDTH-1:0] addra,
  output logic [G_DATAWIDTH-1:0] dina,
  output logic                   enb,
  output logic [G_ADDRWIDTH-1:0] addrb,
  input  logic [G_DATAWIDTH-1:0] doutb
);

  // Pointers hold the index of the last granted requester; reset to 1 so m0 wins first.
  logic                   r_ptr_w;
  logic                   r_ptr_r;

  logic                   w_wgnt0;
  logic                   w_wgnt1;
  logic                   w_rsel0;
  logic                   w_rsel1;
  logic                   w_rgnt0;
  logic                   w_rgnt1;
  logic                   w_ena;
  logic                   w_enb;
  logic                   w_collide;
  logic [G_ADDRWIDTH-1:0] w_waddr_win;
  logic [G_ADDRWIDTH-1:0] w_raddr_win;

  logic [G_RD_LATENCY-1:0] r_vld_p;
  logic [G_RD_LATENCY-1:0] r_own_p;

  // Stage p0: combinational arbitration of both ports in the request cycle
  always_comb begin
    w_wgnt0 = 1'b0;
    w_wgnt1 = 1'b0;
    if (!rst) begin
      if (m0_wr_valid && m1_wr_valid) begin
        w_wgnt0 = r_ptr_w;
        w_wgnt1 = !r_ptr_w;
      end else begin
        w_wgnt0 = m0_wr_valid;
        w_wgnt1 = m1_wr_valid;
      end
    end
  end

  always_comb begin
    w_rsel0 = 1'b0;
    w_rsel1 = 1'b0;
    if (!rst) begin
      if (m0_rd_valid && m1_rd_valid) begin
        w_rsel0 = r_ptr_r;
        w_rsel1 = !r_ptr_r;
      end else begin
        w_rsel0 = m0_rd_valid;
        w_rsel1 = m1_rd_valid;
      end
    end
  end

  assign w_ena       = w_wgnt0 | w_wgnt1;
  assign w_waddr_win = w_wgnt1 ? m1_waddr : m0_waddr;
  assign w_raddr_win = w_rsel1 ? m1_raddr : m0_raddr;

  // A read that targets the address being written this cycle waits one cycle so it sees the new data.
  assign w_collide = (G_COLLISION_STALL != 0) && w_ena && (w_rsel0 || w_rsel1) &&
                     (w_raddr_win == w_waddr_win);

  assign w_rgnt0 = w_rsel0 && !w_collide;
  assign w_rgnt1 = w_rsel1 && !w_collide;
  assign w_enb   = w_rgnt0 | w_rgnt1;

  assign m0_wr_ready = w_wgnt0;
  assign m1_wr_ready = w_wgnt1;
  assign m0_rd_ready = w_rgnt0;
  assign m1_rd_ready = w_rgnt1;

  assign ena   = w_ena;
  assign wea   = w_wgnt0 ? m0_wstrb : (w_wgnt1 ? m1_wstrb : '0);
  assign addra = rst ? '0 : w_waddr_win;
  assign dina  = rst ? '0 : (w_wgnt1 ? m1_wdata : m0_wdata);
  assign enb   = w_enb;
  assign addrb = rst ? '0 : w_raddr_win;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_w <= 1'b1;
      r_ptr_r <= 1'b1;
    end else begin
      if (w_ena) r_ptr_w <= w_wgnt1;
      if (w_enb) r_ptr_r <= w_rgnt1;
    end
  end

  // Stages p1..pN: return pipe tracking read owner, aligned with the memory read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= w_enb;
      for (int i = 1; i < G_RD_LATENCY; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_own_p[0] <= w_rgnt1;
    for (int i = 1; i < G_RD_LATENCY; i++) begin
      r_own_p[i] <= r_own_p[i-1];
    end
  end

  assign m0_rvalid = !rst && r_vld_p[G_RD_LATENCY-1] && !r_own_p[G_RD_LATENCY-1];
  assign m1_rvalid = !rst && r_vld_p[G_RD_LATENCY-1] &&  r_own_p[G_RD_LATENCY-1];
  assign m0_rdata  = doutb;
  assign m1_rdata  = doutb;

endmodule

// File: tb/tb_blockmem_2p_arbiter.sv
// Bench for blockmem_2p_arbiter: memory model, vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference of the arbitration rules.
module tb_blockmem_2p_arbiter;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int WEW   = 4;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  logic m0_wr_valid, m0_wr_ready, m0_rd_valid, m0_rd_ready, m0_rvalid;
  logic m1_wr_valid, m1_wr_ready, m1_rd_valid, m1_rd_ready, m1_rvalid;
  logic [AW-1:0]  m0_waddr, m1_waddr, m0_raddr, m1_raddr, addra, addrb;
  logic [DW-1:0]  m0_wdata, m1_wdata, m0_rdata, m1_rdata, dina, doutb;
  logic [WEW-1:0] m0_wstrb, m1_wstrb, wea;
  logic ena, enb;

  always #5 clk = ~clk;

  blockmem_2p_arbiter #(
    .G_DATAWIDTH(DW), .G_MEMDEPTH(DEPTH), .G_RD_LATENCY(LAT), .G_COLLISION_STALL(1)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_wr_valid(m0_wr_valid), .m0_wr_ready(m0_wr_ready), .m0_waddr(m0_waddr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rd_valid(m0_rd_valid),
    .m0_rd_ready(m0_rd_ready), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_wr_valid(m1_wr_valid), .m1_wr_ready(m1_wr_ready), .m1_waddr(m1_waddr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rd_valid(m1_rd_valid),
    .m1_rd_ready(m1_rd_ready), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb)
  );

  // Block memory model: byte-enabled write port, read-first read port with LAT cycles of latency
  logic [DW-1:0] mem   [DEPTH];
  logic [DW-1:0] rpipe [LAT];
  always @(posedge clk) begin
    if (ena) begin
      for (int b = 0; b < WEW; b++) begin
        if (wea[b]) mem[addra][8*b +: 8] <= dina[8*b +: 8];
      end
    end
    rpipe[0] <= mem[addrb];
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign doutb = rpipe[LAT-1];

  typedef struct {
    bit             rst;
    bit [1:0]       wv;
    bit [1:0]       rv;
    logic [AW-1:0]  wa0, wa1, ra0, ra1;
    logic [DW-1:0]  wd0, wd1;
    logic [WEW-1:0] ws0, ws1;
  } stim_t;

  typedef struct {
    stim_t         s;
    bit [1:0]      e_wr;
    bit [1:0]      e_rd;
    bit [1:0]      e_rv;
    logic [DW-1:0] e_dat;
  } vec_t;

  typedef struct {
    int            due;
    int            own;
    logic [DW-1:0] data;
  } ret_t;

  // Reference state
  logic [DW-1:0] ref_mem [DEPTH];
  ret_t          inflight[$];
  int            ptr_w = 1;
  int            ptr_r = 1;
  int            cyc = 0;

  int total = 0;
  int bad   = 0;

  logic [1:0]    smp_wr, smp_rd, smp_rv;
  logic [DW-1:0] smp_d0, smp_d1;

  vec_t tbl [16];

  function automatic logic [DW-1:0] preval(input int a);
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  function automatic stim_t mk(input bit r, input bit [1:0] wv, input bit [1:0] rv,
                               input int wa0, input int wa1, input int ra0, input int ra1,
                               input logic [DW-1:0] wd0, input logic [DW-1:0] wd1);
    stim_t s;
    s.rst = r;   s.wv = wv;   s.rv = rv;
    s.wa0 = AW'(wa0); s.wa1 = AW'(wa1);
    s.ra0 = AW'(ra0); s.ra1 = AW'(ra1);
    s.wd0 = wd0; s.wd1 = wd1;
    s.ws0 = '1;  s.ws1 = '1;
    return s;
  endfunction

  function automatic int pick(input bit [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic setrow(input int i, input stim_t s, input bit [1:0] ewr, input bit [1:0] erd,
                        input bit [1:0] erv, input logic [DW-1:0] edat);
    tbl[i].s = s; tbl[i].e_wr = ewr; tbl[i].e_rd = erd;
    tbl[i].e_rv = erv; tbl[i].e_dat = edat;
  endtask

  // One clock cycle: drive, predict, sample at negedge, compare, advance the reference.
  task automatic cycle(input stim_t s);
    int            wg, rg;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    logic [WEW-1:0] ws;
    bit [1:0]      exp_rv;
    logic [DW-1:0] exp_d;
    rst = s.rst;
    m0_wr_valid = s.wv[0]; m1_wr_valid = s.wv[1];
    m0_waddr = s.wa0; m1_waddr = s.wa1;
    m0_wdata = s.wd0; m1_wdata = s.wd1;
    m0_wstrb = s.ws0; m1_wstrb = s.ws1;
    m0_rd_valid = s.rv[0]; m1_rd_valid = s.rv[1];
    m0_raddr = s.ra0; m1_raddr = s.ra1;

    wg = -1; rg = -1;
    if (!s.rst) begin
      wg = pick(s.wv, ptr_w);
      rg = pick(s.rv, ptr_r);
    end
    wa = (wg == 1) ? s.wa1 : s.wa0;
    wd = (wg == 1) ? s.wd1 : s.wd0;
    ws = (wg == 1) ? s.ws1 : s.ws0;
    ra = (rg == 1) ? s.ra1 : s.ra0;
    if (wg >= 0 && rg >= 0 && ra == wa) rg = -1;

    exp_rv = 2'b00;
    exp_d  = '0;
    if (!s.rst && inflight.size() > 0 && inflight[0].due == cyc) begin
      exp_rv[inflight[0].own] = 1'b1;
      exp_d = inflight[0].data;
      void'(inflight.pop_front());
    end

    @(negedge clk);
    smp_wr = {m1_wr_ready, m0_wr_ready};
    smp_rd = {m1_rd_ready, m0_rd_ready};
    smp_rv = {m1_rvalid, m0_rvalid};
    smp_d0 = m0_rdata;
    smp_d1 = m1_rdata;

    chk("m0_wr_ready", 32'(m0_wr_ready), 32'(wg == 0));
    chk("m1_wr_ready", 32'(m1_wr_ready), 32'(wg == 1));
    chk("m0_rd_ready", 32'(m0_rd_ready), 32'(rg == 0));
    chk("m1_rd_ready", 32'(m1_rd_ready), 32'(rg == 1));
    chk("ena", 32'(ena), 32'(wg >= 0));
    chk("enb", 32'(enb), 32'(rg >= 0));
    if (wg >= 0) begin
      chk("addra", 32'(addra), 32'(wa));
      chk("dina", dina, wd);
      chk("wea", 32'(wea), 32'(ws));
    end else begin
      chk("wea_idle", 32'(wea), 32'd0);
    end
    if (rg >= 0) chk("addrb", 32'(addrb), 32'(ra));
    if (s.rst) begin
      chk("addra_rst", 32'(addra), 32'd0);
      chk("dina_rst", dina, 32'd0);
      chk("addrb_rst", 32'(addrb), 32'd0);
    end
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    if (exp_rv[0]) chk("m0_rdata", m0_rdata, exp_d);
    if (exp_rv[1]) chk("m1_rdata", m1_rdata, exp_d);

    if (s.rst) begin
      inflight.delete();
      ptr_w = 1;
      ptr_r = 1;
    end else begin
      if (rg >= 0) begin
        inflight.push_back('{cyc + LAT, rg, ref_mem[ra]});
        ptr_r = rg;
      end
      if (wg >= 0) begin
        for (int b = 0; b < WEW; b++) begin
          if (ws[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
        end
        ptr_w = wg;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  stim_t idle;
  logic [1:0]    rv_hist [6];
  logic [DW-1:0] d_hist  [6];

  initial begin
    idle = mk(0, 2'b00, 2'b00, 0, 0, 0, 0, '0, '0);

    // rows: reset with everything requesting, then write/read contention, then collision stall
    setrow(0,  mk(1, 2'b11, 2'b11, 1, 2, 3, 4, 32'h1, 32'h2), 2'b00, 2'b00, 2'b00, '0);
    setrow(1,  mk(1, 2'b11, 2'b11, 1, 2, 3, 4, 32'h1, 32'h2), 2'b00, 2'b00, 2'b00, '0);
    setrow(2,  mk(1, 2'b11, 2'b11, 1, 2, 3, 4, 32'h1, 32'h2), 2'b00, 2'b00, 2'b00, '0);
    setrow(3,  mk(0, 2'b11, 2'b11, 'h30, 'h38, 'h05, 'h06, 32'hA0, 32'hB0), 2'b01, 2'b01, 2'b00, '0);
    setrow(4,  mk(0, 2'b11, 2'b11, 'h31, 'h39, 'h05, 'h06, 32'hA1, 32'hB1), 2'b10, 2'b10, 2'b00, '0);
    setrow(5,  mk(0, 2'b11, 2'b00, 'h32, 'h3A, 0, 0, 32'hA2, 32'hB2), 2'b01, 2'b00, 2'b01, preval(5));
    setrow(6,  mk(0, 2'b11, 2'b00, 'h33, 'h3B, 0, 0, 32'hA3, 32'hB3), 2'b10, 2'b00, 2'b10, preval(6));
    setrow(7,  mk(0, 2'b11, 2'b00, 'h34, 'h3C, 0, 0, 32'hA4, 32'hB4), 2'b01, 2'b00, 2'b00, '0);
    setrow(8,  mk(0, 2'b11, 2'b00, 'h35, 'h3D, 0, 0, 32'hA5, 32'hB5), 2'b10, 2'b00, 2'b00, '0);
    setrow(9,  mk(0, 2'b10, 2'b00, 0, 'h3E, 0, 0, 32'h0, 32'hB6), 2'b10, 2'b00, 2'b00, '0);
    setrow(10, mk(0, 2'b10, 2'b00, 0, 'h3F, 0, 0, 32'h0, 32'hB7), 2'b10, 2'b00, 2'b00, '0);
    setrow(11, mk(0, 2'b11, 2'b00, 'h36, 'h37, 0, 0, 32'hA6, 32'hB8), 2'b01, 2'b00, 2'b00, '0);
    setrow(12, mk(0, 2'b01, 2'b10, 'h20, 0, 0, 'h20, 32'h12345678, 32'h0), 2'b01, 2'b00, 2'b00, '0);
    setrow(13, mk(0, 2'b00, 2'b10, 0, 0, 0, 'h20, 32'h0, 32'h0), 2'b00, 2'b10, 2'b00, '0);
    setrow(14, idle, 2'b00, 2'b00, 2'b00, '0);
    setrow(15, idle, 2'b00, 2'b00, 2'b10, 32'h12345678);

    cycle(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, '0, '0));
    cycle(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, '0, '0));

    // preload addresses 0..63 so every later read has a known value
    for (int a = 0; a < 64; a++) cycle(mk(0, 2'b01, 2'b00, a, 0, 0, 0, preval(a), '0));

    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].s);
      chk($sformatf("tbl%0d_wr", i), 32'(smp_wr), 32'(tbl[i].e_wr));
      chk($sformatf("tbl%0d_rd", i), 32'(smp_rd), 32'(tbl[i].e_rd));
      chk($sformatf("tbl%0d_rv", i), 32'(smp_rv), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv[0]) chk($sformatf("tbl%0d_d0", i), smp_d0, tbl[i].e_dat);
      if (tbl[i].e_rv[1]) chk($sformatf("tbl%0d_d1", i), smp_d1, tbl[i].e_dat);
    end

    // write then read-back by the other requester
    cycle(mk(0, 2'b01, 2'b00, 'h10, 0, 0, 0, 32'hDEADBEEF, '0));
    cycle(mk(0, 2'b00, 2'b10, 0, 0, 0, 'h10, '0, '0));
    cycle(idle);
    cycle(idle);
    chk("wb_m1_rvalid", 32'(smp_rv[1]), 32'd1);
    chk("wb_m0_rvalid", 32'(smp_rv[0]), 32'd0);
    chk("wb_m1_rdata", smp_d1, 32'hDEADBEEF);

    // back-to-back alternating reads
    cycle(mk(0, 2'b00, 2'b01, 0, 0, 1, 0, '0, '0));  rv_hist[0] = smp_rv; d_hist[0] = smp_d0;
    cycle(mk(0, 2'b00, 2'b10, 0, 0, 0, 2, '0, '0));  rv_hist[1] = smp_rv; d_hist[1] = smp_d0;
    cycle(mk(0, 2'b00, 2'b01, 0, 0, 3, 0, '0, '0));  rv_hist[2] = smp_rv; d_hist[2] = smp_d0;
    cycle(mk(0, 2'b00, 2'b10, 0, 0, 0, 4, '0, '0));  rv_hist[3] = smp_rv; d_hist[3] = smp_d0;
    cycle(idle);                                     rv_hist[4] = smp_rv; d_hist[4] = smp_d0;
    cycle(idle);                                     rv_hist[5] = smp_rv; d_hist[5] = smp_d0;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("b2b%0d_owner", j), 32'(rv_hist[j+2]), (j % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("b2b%0d_data", j), d_hist[j+2], preval(j + 1));
    end

    // reset while a read is in flight
    cycle(mk(0, 2'b00, 2'b01, 0, 0, 7, 0, '0, '0));
    cycle(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, '0, '0));
    chk("rstfl_rv_a", 32'(smp_rv), 32'd0);
    cycle(idle);
    chk("rstfl_rv_b", 32'(smp_rv), 32'd0);
    cycle(idle);
    chk("rstfl_rv_c", 32'(smp_rv), 32'd0);
    cycle(mk(0, 2'b00, 2'b01, 0, 0, 7, 0, '0, '0));
    cycle(idle);
    cycle(idle);
    chk("postrst_rv", 32'(smp_rv), 32'd1);
    chk("postrst_data", smp_d0, preval(7));

    // randomized traffic on a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      stim_t s;
      s = mk($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             $urandom, $urandom);
      s.ws0 = WEW'($urandom_range(0, 15));
      s.ws1 = WEW'($urandom_range(0, 15));
      cycle(s);
    end
    for (int k = 0; k < LAT + 1; k++) cycle(idle);
    chk("drain_empty", 32'(inflight.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
